processador_tiro: RTL and testbench

PROCESSADOR_TIRO -- requirements
Module: processador_tiro

---
 rtl/processador_tiro_pkg.sv | 38 +++
 rtl/processador_tiro_atualiza_celula.sv | 24 ++
 rtl/processador_tiro.sv | 190 +++++++++++++++++++
 tb/tb_processador_tiro.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/processador_tiro_pkg.sv
// Shared definitions for the shot processor and the board memory:
// cell codes, FSM state encoding, board geometry and bus widths.
package processador_tiro_pkg;

    // Default board geometry (rows x 2-bit cells per row)
    localparam int ROWS_DEF       = 11;
    localparam int COLS_DEF       = 18;
    localparam int SHIP_CELLS_DEF = 17;

    // Bus widths shared with the board memory
    localparam int ROW_W  = 4;
    localparam int COL_W  = 5;
    localparam int DATA_W = 2 * COLS_DEF;
    localparam int CNT_W  = 8;

    // Cell encoding, cell c lives in bits [2c+1:2c] of a row
    typedef enum logic [1:0] {
        CELL_WATER = 2'b00,
        CELL_SHIP  = 2'b01,
        CELL_MISS  = 2'b10,
        CELL_HIT   = 2'b11
    } cell_t;

    // Shot processing FSM
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_EVAL  = 3'd2,
        ST_WRITE = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    // A cell that has already been shot at (miss or hit marker)
    function automatic logic cell_is_marked(input logic [1:0] code);
        return code[1];
    endfunction

endpackage

// File: rtl/processador_tiro_atualiza_celula.sv
// Combinational row update: returns the input row with only cell col
// replaced by the given 2-bit code.
module processador_tiro_atualiza_celula
    import processador_tiro_pkg::*;
#(
    parameter int COLS = COLS_DEF
) (
    input  logic [2*COLS-1:0] row_in,
    input  logic [COL_W-1:0]  col,
    input  logic [1:0]        code,
    output logic [2*COLS-1:0] row_out
);

    // Pass every cell through except the addressed one
    always_comb begin
        row_out = row_in;
        for (int c = 0; c < COLS; c++) begin
            if (col == COL_W'(c)) begin
                row_out[2*c +: 2] = code;
            end
        end
    end

endmodule

// File: rtl/processador_tiro.sv
// Battleship shot processor: accepts a shot, reads the target row from the
// board memory, marks the cell, writes it back and reports hit/miss/repeat.
module processador_tiro
    import processador_tiro_pkg::*;
#(
    parameter int ROWS       = ROWS_DEF,
    parameter int COLS       = COLS_DEF,
    parameter int SHIP_CELLS = SHIP_CELLS_DEF
) (
    input  logic              clk,
    input  logic              rst,
    // Shot request: accepted on a rising edge where shot_valid && shot_ready.
    // shot_row/shot_col are latched on that edge; requests made while
    // shot_ready is low are dropped, never queued.
    input  logic              shot_valid,
    output logic              shot_ready,
    input  logic [ROW_W-1:0]  shot_row,
    input  logic [COL_W-1:0]  shot_col,
    // Board memory port (read data returns the cycle after mem_addr is sampled)
    output logic              mem_we,
    output logic [ROW_W-1:0]  mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    // Result, qualifiers are forced low outside the res_valid strobe
    output logic              res_valid,
    output logic              res_hit,
    output logic              res_repeat,
    output logic              res_invalid,
    output logic [CNT_W-1:0]  hit_count,
    output logic              game_over,
    // Current FSM state, for observation only
    output state_t            dbg_state
);

    localparam logic [ROW_W-1:0] ROWS_L = ROW_W'(ROWS);
    localparam logic [COL_W-1:0] COLS_L = COL_W'(COLS);
    localparam logic [CNT_W-1:0] SHIP_L = CNT_W'(SHIP_CELLS);

    state_t              state_q, state_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic                hit_f_q, hit_f_d;
    logic                rep_f_q, rep_f_d;
    logic                inv_f_q, inv_f_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [CNT_W-1:0]    hit_count_q, hit_count_d;
    logic                game_over_q, game_over_d;
    logic                shot_ready_q, shot_ready_d;
    logic                mem_we_q, mem_we_d;
    logic [ROW_W-1:0]    mem_addr_q, mem_addr_d;
    logic                res_valid_q, res_valid_d;
    logic                res_hit_q, res_hit_d;
    logic                res_repeat_q, res_repeat_d;
    logic                res_invalid_q, res_invalid_d;

    logic [1:0]          old_cell;
    logic [1:0]          new_cell;
    logic [DATA_W-1:0]   upd_row;
    logic                shot_bad;

    // Cell under the latched column in the row returned by the memory
    assign old_cell = mem_rdata[{col_q, 1'b0} +: 2];
    assign new_cell = (old_cell == CELL_SHIP) ? CELL_HIT : CELL_MISS;
    assign shot_bad = (shot_row >= ROWS_L) || (shot_col >= COLS_L);

    processador_tiro_atualiza_celula #(
        .COLS (COLS)
    ) u_atualiza_celula (
        .row_in  (mem_rdata),
        .col     (col_q),
        .code    (new_cell),
        .row_out (upd_row)
    );

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        hit_f_d     = hit_f_q;
        rep_f_d     = rep_f_q;
        inv_f_d     = inv_f_q;
        wdata_d     = wdata_q;
        hit_count_d = hit_count_q;
        game_over_d = game_over_q;

        case (state_q)
            ST_IDLE: begin
                if (shot_valid && shot_ready_q) begin
                    row_d   = shot_row;
                    col_d   = shot_col;
                    hit_f_d = 1'b0;
                    rep_f_d = 1'b0;
                    inv_f_d = shot_bad;
                    state_d = shot_bad ? ST_RESP : ST_READ;
                end
            end
            ST_READ: begin
                state_d = ST_EVAL;
            end
            ST_EVAL: begin
                // mem_rdata now holds the addressed row
                state_d = ST_WRITE;
                wdata_d = upd_row;
                if (cell_is_marked(old_cell)) begin
                    rep_f_d = 1'b1;
                end else if (old_cell == CELL_SHIP) begin
                    hit_f_d = 1'b1;
                    if (hit_count_q != {CNT_W{1'b1}}) begin
                        hit_count_d = hit_count_q + 1'b1;
                    end
                    if (hit_count_d == SHIP_L) begin
                        game_over_d = 1'b1;
                    end
                end
            end
            ST_WRITE: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered, so decode them from the next state
        shot_ready_d  = (state_d == ST_IDLE) && !game_over_d;
        mem_addr_d    = ((state_d == ST_READ) || (state_d == ST_EVAL) ||
                         (state_d == ST_WRITE)) ? row_d : '0;
        mem_we_d      = (state_d == ST_WRITE) && !rep_f_d;
        res_valid_d   = (state_d == ST_RESP);
        res_hit_d     = res_valid_d && hit_f_d;
        res_repeat_d  = res_valid_d && rep_f_d;
        res_invalid_d = res_valid_d && inv_f_d;
    end

    // State and output registers; reset drops mem_we at once, aborting a write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            row_q         <= '0;
            col_q         <= '0;
            hit_f_q       <= 1'b0;
            rep_f_q       <= 1'b0;
            inv_f_q       <= 1'b0;
            wdata_q       <= '0;
            hit_count_q   <= '0;
            game_over_q   <= 1'b0;
            shot_ready_q  <= 1'b1;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            res_valid_q   <= 1'b0;
            res_hit_q     <= 1'b0;
            res_repeat_q  <= 1'b0;
            res_invalid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            row_q         <= row_d;
            col_q         <= col_d;
            hit_f_q       <= hit_f_d;
            rep_f_q       <= rep_f_d;
            inv_f_q       <= inv_f_d;
            wdata_q       <= wdata_d;
            hit_count_q   <= hit_count_d;
            game_over_q   <= game_over_d;
            shot_ready_q  <= shot_ready_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            res_valid_q   <= res_valid_d;
            res_hit_q     <= res_hit_d;
            res_repeat_q  <= res_repeat_d;
            res_invalid_q <= res_invalid_d;
        end
    end

    assign shot_ready  = shot_ready_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = wdata_q;
    assign res_valid   = res_valid_q;
    assign res_hit     = res_hit_q;
    assign res_repeat  = res_repeat_q;
    assign res_invalid = res_invalid_q;
    assign hit_count   = hit_count_q;
    assign game_over   = game_over_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_processador_tiro.sv
// Directed bench for processador_tiro with a behavioural board memory.
module tb_processador_tiro;
    import processador_tiro_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        shot_valid = 1'b0;
    logic        shot_ready;
    logic [3:0]  shot_row = '0;
    logic [4:0]  shot_col = '0;
    logic        mem_we;
    logic [3:0]  mem_addr;
    logic [35:0] mem_wdata;
    logic [35:0] mem_rdata;
    logic        res_valid, res_hit, res_repeat, res_invalid;
    logic [7:0]  hit_count;
    logic        game_over;
    state_t      dbg_state;

    int n_cmp = 0;
    int n_err = 0;

    // Board memory model with a bench-side load port
    logic [35:0] board [0:15];
    logic        ld_en = 1'b0;
    logic [3:0]  ld_addr = '0;
    logic [35:0] ld_data = '0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        mem_rdata <= board[mem_addr];
        if (ld_en) board[ld_addr] <= ld_data;
        else if (mem_we) board[mem_addr] <= mem_wdata;
    end

    processador_tiro dut (
        .clk         (clk),
        .rst         (rst),
        .shot_valid  (shot_valid),
        .shot_ready  (shot_ready),
        .shot_row    (shot_row),
        .shot_col    (shot_col),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .res_valid   (res_valid),
        .res_hit     (res_hit),
        .res_repeat  (res_repeat),
        .res_invalid (res_invalid),
        .hit_count   (hit_count),
        .game_over   (game_over),
        .dbg_state   (dbg_state)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_row(input logic [3:0] a, input logic [35:0] d);
        @(negedge clk);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    // Issue one shot and observe 6 cycles after the accept edge.
    // res_cyc = cycle (1-based after accept) of the result strobe, -1 if refused.
    task automatic do_shot(input logic [3:0] r, input logic [4:0] c, input bit poke,
                           output int res_cyc, output logic hit, output logic rep,
                           output logic inv, output int we_n, output logic [35:0] wd,
                           output logic [3:0] addr1, output logic rdy1, output int qual_bad);
        res_cyc = 0; hit = 0; rep = 0; inv = 0; we_n = 0; wd = '0;
        addr1 = '0; rdy1 = 1'b1; qual_bad = 0;
        @(negedge clk);
        if (!shot_ready) begin
            res_cyc = -1;
            return;
        end
        shot_valid = 1'b1; shot_row = r; shot_col = c;
        @(posedge clk);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) begin
                shot_valid = 1'b0;
                addr1 = mem_addr;
                rdy1 = shot_ready;
            end
            if (poke && k == 2) begin
                shot_valid = 1'b1; shot_row = 4'd7; shot_col = 5'd0;
            end
            if (poke && k == 3) shot_valid = 1'b0;
            if (res_valid) begin
                if (res_cyc == 0) res_cyc = k;
                hit = res_hit; rep = res_repeat; inv = res_invalid;
            end else if (res_hit || res_repeat || res_invalid) begin
                qual_bad++;
            end
            if (mem_we) begin
                we_n++;
                wd = mem_wdata;
            end
        end
    endtask

    initial begin
        int rc, wn, qb;
        logic h, rp, iv, rdy;
        logic [35:0] wd;
        logic [3:0] a1;

        // Clock/reset
        repeat (2) @(negedge clk);
        chk("rst_ready", shot_ready, 1'b1);
        chk("rst_we", mem_we, 1'b0);
        chk("rst_addr", mem_addr, 4'd0);
        chk("rst_res_valid", res_valid, 1'b0);
        chk("rst_hit_count", hit_count, 8'd0);
        chk("rst_game_over", game_over, 1'b0);
        chk("rst_state", dbg_state, ST_IDLE);

        for (int i = 0; i < 16; i++) load_row(4'(i), 36'h0);
        load_row(4'd3, 36'h0_0000_0004);
        load_row(4'd0, 36'h0_5555_5555);
        load_row(4'd9, 36'h0_0000_0010);
        @(negedge clk);
        rst = 1'b0;

        // Hit on (3,1)
        do_shot(4'd3, 5'd1, 1'b0, rc, h, rp, iv, wn, wd, a1, rdy, qb);
        chk("hit_res_cyc", 64'(rc), 64'd4);
        chk("hit_res_hit", h, 1'b1);
        chk("hit_res_rep", rp, 1'b0);
        chk("hit_res_inv", iv, 1'b0);
        chk("hit_we_n", 64'(wn), 64'd1);
        chk("hit_wdata", wd, 36'h0_0000_000C);
        chk("hit_addr_read", a1, 4'd3);
        chk("hit_busy_ready", rdy, 1'b0);
        chk("hit_qual_idle", 64'(qb), 64'd0);
        chk("hit_board3", board[3], 36'h0_0000_000C);
        chk("hit_count_1", hit_count, 8'd1);

        // Repeat of (3,1), with a poke while busy that must be dropped
        do_shot(4'd3, 5'd1, 1'b1, rc, h, rp, iv, wn, wd, a1, rdy, qb);
        chk("rep_res_cyc", 64'(rc), 64'd4);
        chk("rep_res_rep", rp, 1'b1);
        chk("rep_res_hit", h, 1'b0);
        chk("rep_we_n", 64'(wn), 64'd0);
        chk("rep_hit_count", hit_count, 8'd1);
        chk("rep_board3", board[3], 36'h0_0000_000C);
        chk("busy_poke_board7", board[7], 36'h0);
        chk("busy_poke_state", dbg_state, ST_IDLE);

        // Miss on water (3,0)
        do_shot(4'd3, 5'd0, 1'b0, rc, h, rp, iv, wn, wd, a1, rdy, qb);
        chk("miss_res_cyc", 64'(rc), 64'd4);
        chk("miss_res_hit", h, 1'b0);
        chk("miss_res_rep", rp, 1'b0);
        chk("miss_we_n", 64'(wn), 64'd1);
        chk("miss_board3", board[3], 36'h0_0000_000E);
        chk("miss_hit_count", hit_count, 8'd1);

        // Invalid row and column
        do_shot(4'd11, 5'd0, 1'b0, rc, h, rp, iv, wn, wd, a1, rdy, qb);
        chk("inv_row_res_cyc", 64'(rc), 64'd1);
        chk("inv_row_inv", iv, 1'b1);
        chk("inv_row_hit", h, 1'b0);
        chk("inv_row_we_n", 64'(wn), 64'd0);
        chk("inv_row_addr", a1, 4'd0);
        do_shot(4'd0, 5'd18, 1'b0, rc, h, rp, iv, wn, wd, a1, rdy, qb);
        chk("inv_col_res_cyc", 64'(rc), 64'd1);
        chk("inv_col_inv", iv, 1'b1);
        chk("inv_col_rep", rp, 1'b0);
        chk("inv_col_we_n", 64'(wn), 64'd0);

        // Sink the remaining 16 ship cells in row 0
        for (int c = 0; c < 16; c++) begin
            do_shot(4'd0, 5'(c), 1'b0, rc, h, rp, iv, wn, wd, a1, rdy, qb);
            if (c == 14) chk("go_before_last", game_over, 1'b0);
        end
        chk("go_last_hit", h, 1'b1);
        chk("go_hit_count", hit_count, 8'd17);
        chk("go_game_over", game_over, 1'b1);
        chk("go_board0", board[0], 36'h0_FFFF_FFFF);
        chk("go_ready", shot_ready, 1'b0);
        @(negedge clk);
        shot_valid = 1'b1; shot_row = 4'd9; shot_col = 5'd2;
        repeat (4) @(negedge clk);
        shot_valid = 1'b0;
        chk("go_ignored_state", dbg_state, ST_IDLE);
        chk("go_ready_hold", shot_ready, 1'b0);
        chk("go_ignored_board9", board[9], 36'h0_0000_0010);

        // Reset pulsed while in WRITE
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst2_ready", shot_ready, 1'b1);
        chk("rst2_game_over", game_over, 1'b0);
        @(negedge clk);
        shot_valid = 1'b1; shot_row = 4'd9; shot_col = 5'd2;
        @(posedge clk);
        @(negedge clk);
        shot_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("wr_state", dbg_state, ST_WRITE);
        chk("wr_we_before_rst", mem_we, 1'b1);
        rst = 1'b1;
        #1;
        chk("wr_we_dropped", mem_we, 1'b0);
        chk("wr_rst_hit_count", hit_count, 8'd0);
        @(negedge clk);
        rst = 1'b0;
        rc = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (res_valid || mem_we) rc++;
        end
        chk("wr_no_result", 64'(rc), 64'd0);
        chk("wr_board9", board[9], 36'h0_0000_0010);
        chk("wr_hit_count", hit_count, 8'd0);
        chk("wr_ready", shot_ready, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
